// File: rtl/pkt_sink_monitor.sv
// Packet stream sink with programmable backpressure, framing checks and packet statistics.
// Optional define SINK_LATENCY_EN adds last_cycles (first-word-to-EOP cycle span of the last packet).
module pkt_sink_monitor #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8,
    parameter int CNT_WIDTH  = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic                  in_wr,
    output logic                  in_rdy,
    input  logic [7:0]            throttle_mask,
    input  logic                  clr_stats,
    output logic                  pkt_done,
    output logic [CNT_WIDTH-1:0]  pkt_count,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [LEN_WIDTH-1:0]  last_len,
    output logic [DATA_WIDTH-1:0] last_xor,
    output logic                  hdr_err,
    output logic                  ovf_err
`ifdef SINK_LATENCY_EN
    ,
    output logic [LEN_WIDTH-1:0]  last_cycles
`endif
);

    typedef enum logic {
        HDR,
        PAYLOAD
    } state_t;

    state_t                state, state_nxt;
    logic [2:0]            phase;
    logic [LEN_WIDTH-1:0]  len_acc, len_nxt, len_inc;
    logic [DATA_WIDTH-1:0] xor_acc, xor_nxt;
    logic                  accept;
    logic                  eop;
    logic                  set_hdr_err;

    assign accept  = in_wr && in_rdy;
    assign len_inc = (len_acc == '1) ? len_acc : len_acc + LEN_WIDTH'(1);

    always_comb begin
        state_nxt   = state;
        len_nxt     = len_acc;
        xor_nxt     = xor_acc;
        eop         = 1'b0;
        set_hdr_err = 1'b0;
        if (accept) begin
            case (state)
                HDR: begin
                    if (in_ctrl != '0) begin
                        len_nxt = len_inc;
                    end else if (len_acc != '0) begin
                        xor_nxt   = in_data;
                        len_nxt   = len_inc;
                        state_nxt = PAYLOAD;
                    end else begin
                        // payload with no preceding header: flagged and discarded
                        set_hdr_err = 1'b1;
                    end
                end
                PAYLOAD: begin
                    if (in_ctrl == '0) begin
                        xor_nxt = xor_acc ^ in_data;
                        len_nxt = len_inc;
                    end else begin
                        eop       = 1'b1;
                        len_nxt   = '0;
                        xor_nxt   = '0;
                        state_nxt = HDR;
                    end
                end
                default: state_nxt = HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HDR;
            phase      <= '0;
            in_rdy     <= 1'b0;
            len_acc    <= '0;
            xor_acc    <= '0;
            pkt_done   <= 1'b0;
            pkt_count  <= '0;
            word_count <= '0;
            last_len   <= '0;
            last_xor   <= '0;
            hdr_err    <= 1'b0;
            ovf_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase + 3'd1;
            in_rdy   <= ~throttle_mask[phase];
            len_acc  <= len_nxt;
            xor_acc  <= xor_nxt;
            pkt_done <= eop;
            // a coincident clear overrides every statistics update in the same cycle
            if (clr_stats) begin
                pkt_count  <= '0;
                word_count <= '0;
                last_len   <= '0;
                last_xor   <= '0;
                hdr_err    <= 1'b0;
                ovf_err    <= 1'b0;
            end else begin
                if (accept) word_count <= word_count + CNT_WIDTH'(1);
                if (eop) begin
                    pkt_count <= pkt_count + CNT_WIDTH'(1);
                    last_len  <= len_inc;
                    last_xor  <= xor_acc ^ in_data;
                end
                if (set_hdr_err) hdr_err <= 1'b1;
                if (in_wr && !in_rdy) ovf_err <= 1'b1;
            end
        end
    end

`ifdef SINK_LATENCY_EN
    logic [LEN_WIDTH-1:0] cyc_acc, cyc_inc;

    assign cyc_inc = (cyc_acc == '1) ? cyc_acc : cyc_acc + LEN_WIDTH'(1);

    // a nonzero len_acc means a packet is in flight, so the span counter keeps running through stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_acc     <= '0;
            last_cycles <= '0;
        end else begin
            if (eop) begin
                cyc_acc <= '0;
            end else if (accept && state == HDR && len_acc == '0 && in_ctrl != '0) begin
                cyc_acc <= LEN_WIDTH'(1);
            end else if (len_acc != '0) begin
                cyc_acc <= cyc_inc;
            end
            if (clr_stats) begin
                last_cycles <= '0;
            end else if (eop) begin
                last_cycles <= cyc_inc;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pkt_sink_monitor.sv
// Randomized and directed bench for pkt_sink_monitor against a packet-level reference model.
module tb_pkt_sink_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic [7:0]  in_ctrl;
    logic        in_wr;
    logic        in_rdy;
    logic [7:0]  throttle_mask;
    logic        clr_stats;
    logic        pkt_done;
    logic [31:0] pkt_count;
    logic [31:0] word_count;
    logic [15:0] last_len;
    logic [63:0] last_xor;
    logic        hdr_err;
    logic        ovf_err;
`ifdef SINK_LATENCY_EN
    logic [15:0] last_cycles;
`endif

    int checks = 0;
    int errors = 0;

    // reference model: packet held as a header count plus a queue of payload words
    int          m_phase;
    logic        m_rdy;
    int          m_hdr;
    logic [63:0] m_pay[$];
    logic [31:0] e_pkt_count, e_word_count;
    logic [15:0] e_last_len;
    logic [63:0] e_last_xor;
    logic        e_hdr_err, e_ovf, e_done;
`ifdef SINK_LATENCY_EN
    int          m_cyc, m_start;
    logic [15:0] e_last_cycles;
`endif

    always #5 clk = ~clk;

    pkt_sink_monitor #(
        .DATA_WIDTH(64),
        .CTRL_WIDTH(8),
        .CNT_WIDTH (32),
        .LEN_WIDTH (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_ctrl      (in_ctrl),
        .in_wr        (in_wr),
        .in_rdy       (in_rdy),
        .throttle_mask(throttle_mask),
        .clr_stats    (clr_stats),
        .pkt_done     (pkt_done),
        .pkt_count    (pkt_count),
        .word_count   (word_count),
        .last_len     (last_len),
        .last_xor     (last_xor),
        .hdr_err      (hdr_err),
        .ovf_err      (ovf_err)
`ifdef SINK_LATENCY_EN
        ,
        .last_cycles  (last_cycles)
`endif
    );

    task automatic model_clear_stats();
        e_pkt_count  = '0;
        e_word_count = '0;
        e_last_len   = '0;
        e_last_xor   = '0;
        e_hdr_err    = 1'b0;
        e_ovf        = 1'b0;
`ifdef SINK_LATENCY_EN
        e_last_cycles = '0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1; in_wr = 1'b0; clr_stats = 1'b0; in_ctrl = '0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_phase = 0; m_rdy = 1'b0; m_hdr = 0; m_pay.delete();
        e_done = 1'b0;
        model_clear_stats();
`ifdef SINK_LATENCY_EN
        m_cyc = 0; m_start = 0;
`endif
    endtask

    task automatic cycle(input logic wr, input logic [7:0] ctrl, input logic [63:0] data, input logic clr);
        logic [63:0] x;
        in_wr = wr; in_ctrl = ctrl; in_data = data; clr_stats = clr;
        e_done = 1'b0;
        if (wr && !m_rdy) e_ovf = 1'b1;
        if (wr && m_rdy) begin
            e_word_count++;
            if (m_pay.size() == 0) begin
                if (ctrl != 0) begin
`ifdef SINK_LATENCY_EN
                    if (m_hdr == 0) m_start = m_cyc;
`endif
                    m_hdr++;
                end else if (m_hdr > 0) begin
                    m_pay.push_back(data);
                end else begin
                    e_hdr_err = 1'b1;
                end
            end else if (ctrl == 0) begin
                m_pay.push_back(data);
            end else begin
                x = data;
                foreach (m_pay[i]) x ^= m_pay[i];
                e_last_len = 16'(m_hdr + m_pay.size() + 1);
                e_last_xor = x;
                e_pkt_count++;
                e_done = 1'b1;
`ifdef SINK_LATENCY_EN
                e_last_cycles = 16'(m_cyc - m_start + 1);
`endif
                m_hdr = 0;
                m_pay.delete();
            end
        end
        if (clr) model_clear_stats();
        m_rdy   = !throttle_mask[m_phase];
        m_phase = (m_phase + 1) % 8;
`ifdef SINK_LATENCY_EN
        m_cyc++;
`endif
        @(posedge clk);
        #1;
        in_wr = 1'b0; clr_stats = 1'b0;
    endtask

    task automatic send(input logic [7:0] ctrl, input logic [63:0] data, input logic clr);
        for (int i = 0; i < 32 && !m_rdy; i++) cycle(1'b0, '0, '0, 1'b0);
        if (!m_rdy) begin
            checks++; errors++;
            $display("FAIL send_timeout in_rdy never expected high (got %0b exp 1)", in_rdy);
        end
        cycle(1'b1, ctrl, data, clr);
    endtask

    task automatic send_pkt(input int n_pay, output logic [63:0] x);
        logic [63:0] d;
        send(8'hFF, {$urandom, $urandom}, 1'b0);
        x = '0;
        for (int i = 0; i < n_pay; i++) begin
            d = {$urandom, $urandom};
            x ^= d;
            send(8'h00, d, 1'b0);
        end
        d = {$urandom, $urandom};
        x ^= d;
        send(8'h01, d, 1'b0);
    endtask

    task automatic test_reset();
        throttle_mask = 8'h00;
        do_reset();
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy got %0b exp 0", in_rdy); end
        checks++; if ({pkt_done, hdr_err, ovf_err} !== 3'b000) begin errors++; $display("FAIL rst_flags got %03b exp 000", {pkt_done, hdr_err, ovf_err}); end
        checks++; if ({pkt_count, word_count} !== 64'd0) begin errors++; $display("FAIL rst_counts got %0h exp 0", {pkt_count, word_count}); end
        checks++; if (last_len !== 16'd0 || last_xor !== 64'd0) begin errors++; $display("FAIL rst_last got %0h/%0h exp 0/0", last_len, last_xor); end
        cycle(1'b0, '0, '0, 1'b0);
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy_after got %0b exp 1", in_rdy); end
    endtask

    task automatic test_basic();
        throttle_mask = 8'h00;
        do_reset();
        send(8'hFF, {$urandom, $urandom}, 1'b0);
        send(8'h00, 64'h1, 1'b0);
        send(8'h00, 64'h2, 1'b0);
        send(8'h00, 64'h4, 1'b0);
        send(8'h01, 64'h8, 1'b0);
        checks++; if (pkt_done !== 1'b1) begin errors++; $display("FAIL basic_done got %0b exp 1", pkt_done); end
        checks++; if (last_len !== 16'd5) begin errors++; $display("FAIL basic_len got %0d exp 5", last_len); end
        checks++; if (last_xor !== 64'hF) begin errors++; $display("FAIL basic_xor got %0h exp f", last_xor); end
        checks++; if (pkt_count !== 32'd1 || word_count !== 32'd5) begin errors++; $display("FAIL basic_counts got %0d/%0d exp 1/5", pkt_count, word_count); end
        checks++; if (hdr_err !== 1'b0 || ovf_err !== 1'b0) begin errors++; $display("FAIL basic_err got %0b%0b exp 00", hdr_err, ovf_err); end
        cycle(1'b0, '0, '0, 1'b0);
        checks++; if (pkt_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %0b exp 0", pkt_done); end
    endtask

    task automatic test_throttle();
        logic prev;
        throttle_mask = 8'hAA;
        do_reset();
        cycle(1'b0, '0, '0, 1'b0);
        prev = in_rdy;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, '0, '0, 1'b0);
            checks++; if (in_rdy !== ~prev) begin errors++; $display("FAIL thr_period got %0b exp %0b", in_rdy, ~prev); end
            prev = in_rdy;
        end
        send(8'hFF, 64'hDEAD, 1'b0);
        send(8'h00, 64'h1, 1'b0);
        send(8'h00, 64'h2, 1'b0);
        send(8'h00, 64'h4, 1'b0);
        send(8'h01, 64'h8, 1'b0);
        checks++; if (last_len !== 16'd5 || last_xor !== 64'hF) begin errors++; $display("FAIL thr_stats got %0d/%0h exp 5/f", last_len, last_xor); end
        checks++; if (pkt_count !== 32'd1 || word_count !== 32'd5 || ovf_err !== 1'b0) begin errors++; $display("FAIL thr_counts got %0d/%0d/%0b exp 1/5/0", pkt_count, word_count, ovf_err); end
`ifdef SINK_LATENCY_EN
        checks++; if (last_cycles !== 16'd9) begin errors++; $display("FAIL thr_cycles got %0d exp 9", last_cycles); end
`endif
    endtask

    task automatic test_hdr_err();
        logic [63:0] x;
        throttle_mask = 8'h00;
        do_reset();
        send(8'h00, 64'h55, 1'b0);
        checks++; if (hdr_err !== 1'b1) begin errors++; $display("FAIL hdr_flag got %0b exp 1", hdr_err); end
        checks++; if (word_count !== 32'd1 || pkt_count !== 32'd0) begin errors++; $display("FAIL hdr_counts got %0d/%0d exp 1/0", word_count, pkt_count); end
        send_pkt(2, x);
        checks++; if (pkt_count !== 32'd1 || last_len !== 16'd4) begin errors++; $display("FAIL hdr_next got %0d/%0d exp 1/4", pkt_count, last_len); end
        checks++; if (last_xor !== x) begin errors++; $display("FAIL hdr_next_xor got %0h exp %0h", last_xor, x); end
    endtask

    task automatic test_ovf();
        throttle_mask = 8'hFF;
        do_reset();
        repeat (3) cycle(1'b0, '0, '0, 1'b0);
        cycle(1'b1, 8'hFF, 64'h1234, 1'b0);
        checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b exp 1", ovf_err); end
        checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL ovf_words got %0d exp 0", word_count); end
        cycle(1'b0, '0, '0, 1'b1);
        checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b exp 0", ovf_err); end
    endtask

    task automatic test_rst_abort();
        throttle_mask = 8'h00;
        do_reset();
        send(8'hFF, 64'h0, 1'b0);
        send(8'h00, 64'hF0F0, 1'b0);
        send(8'h00, 64'h0F00, 1'b0);
        do_reset();
        send(8'hFF, 64'hAAAA, 1'b0);
        send(8'h00, 64'h10, 1'b0);
        send(8'h00, 64'h20, 1'b0);
        send(8'h01, 64'h40, 1'b0);
        checks++; if (pkt_count !== 32'd1 || last_len !== 16'd4) begin errors++; $display("FAIL abort_stats got %0d/%0d exp 1/4", pkt_count, last_len); end
        checks++; if (last_xor !== 64'h70) begin errors++; $display("FAIL abort_xor got %0h exp 70", last_xor); end
    endtask

    task automatic test_clr_collide();
        throttle_mask = 8'h00;
        do_reset();
        send(8'hFF, 64'h1, 1'b0);
        send(8'h00, 64'h2, 1'b0);
        send(8'h01, 64'h3, 1'b1);
        checks++; if (pkt_count !== 32'd0 || last_len !== 16'd0) begin errors++; $display("FAIL clr_win got %0d/%0d exp 0/0", pkt_count, last_len); end
        checks++; if (word_count !== 32'd0 || last_xor !== 64'd0) begin errors++; $display("FAIL clr_win2 got %0d/%0h exp 0/0", word_count, last_xor); end
        send(8'hFF, 64'h1, 1'b0);
        send(8'h00, 64'h6, 1'b0);
        send(8'h02, 64'h9, 1'b0);
        checks++; if (pkt_count !== 32'd1 || last_len !== 16'd3 || last_xor !== 64'hF) begin errors++; $display("FAIL clr_next got %0d/%0d/%0h exp 1/3/f", pkt_count, last_len, last_xor); end
    endtask

    task automatic test_random();
        logic       wr, clr;
        logic [7:0] ctrl;
        throttle_mask = 8'h00;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) throttle_mask = 8'($urandom);
            wr   = m_rdy ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
            ctrl = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            clr  = ($urandom_range(0, 59) == 0);
            cycle(wr, ctrl, {$urandom, $urandom}, clr);
            checks++; if (in_rdy !== m_rdy) begin errors++; $display("FAIL rnd_rdy cyc %0d got %0b exp %0b", i, in_rdy, m_rdy); end
            checks++; if (pkt_done !== e_done) begin errors++; $display("FAIL rnd_done cyc %0d got %0b exp %0b", i, pkt_done, e_done); end
            checks++; if (pkt_count !== e_pkt_count || word_count !== e_word_count) begin errors++; $display("FAIL rnd_counts cyc %0d got %0d/%0d exp %0d/%0d", i, pkt_count, word_count, e_pkt_count, e_word_count); end
            checks++; if (last_len !== e_last_len || last_xor !== e_last_xor) begin errors++; $display("FAIL rnd_last cyc %0d got %0d/%0h exp %0d/%0h", i, last_len, last_xor, e_last_len, e_last_xor); end
            checks++; if (hdr_err !== e_hdr_err || ovf_err !== e_ovf) begin errors++; $display("FAIL rnd_err cyc %0d got %0b%0b exp %0b%0b", i, hdr_err, ovf_err, e_hdr_err, e_ovf); end
`ifdef SINK_LATENCY_EN
            checks++; if (last_cycles !== e_last_cycles) begin errors++; $display("FAIL rnd_cycles cyc %0d got %0d exp %0d", i, last_cycles, e_last_cycles); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_throttle();
        test_hdr_err();
        test_ovf();
        test_rst_abort();
        test_clr_collide();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
